// File: rtl/audio_path_ctrl.sv
// audio_path_ctrl: codec init sequencing and pop-free effect switching.
// Optional clip detector is enabled by defining CLIP_DETECT_EN.
module audio_path_ctrl #(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 2,
    parameter int SEL_W        = 18,
    parameter int RAMP_BITS    = 5,
    parameter int INIT_TIMEOUT = 1000000,
    parameter int RETRY_CYCLES = 1000
) (
    input  logic                     Clk,
    input  logic                     Reset,
    output logic                     init,
    input  logic                     init_finish,
    input  logic                     adc_valid,
    input  logic [NUM_CH*DATA_W-1:0] proc_data,
    input  logic [SEL_W-1:0]         fx_sel,
    output logic [SEL_W-1:0]         fx_sel_out,
    output logic [NUM_CH*DATA_W-1:0] dac_data,
    output logic                     dac_valid,
    output logic [2:0]               state_o,
    output logic                     init_error
`ifdef CLIP_DETECT_EN
    ,
    output logic                     clip_flag
`endif
);

    localparam int G_MAX   = 2 ** RAMP_BITS;
    localparam int GW      = RAMP_BITS + 1;
    localparam int PW      = DATA_W + RAMP_BITS + 1;
    localparam int CNT_MAX = (INIT_TIMEOUT > RETRY_CYCLES) ?
                             INIT_TIMEOUT : RETRY_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [GW-1:0] GMAX_V    = GW'(G_MAX);
    localparam logic [CW-1:0] TIMEOUT_V = CW'(INIT_TIMEOUT - 1);
    localparam logic [CW-1:0] RETRY_V   = CW'(RETRY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HALT     = 3'd0,
        S_INIT     = 3'd1,
        S_ERROR    = 3'd2,
        S_RUN      = 3'd3,
        S_FADE_OUT = 3'd4,
        S_SWITCH   = 3'd5,
        S_FADE_IN  = 3'd6
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [GW-1:0]            gain_q, gain_d;
    logic [SEL_W-1:0]         sync1_q, sync1_d;
    logic [SEL_W-1:0]         sync2_q, sync2_d;
    logic [SEL_W-1:0]         fx_sel_out_q, fx_sel_out_d;
    logic [NUM_CH*DATA_W-1:0] dac_data_q, dac_data_d;
    logic                     dac_valid_q, dac_valid_d;
    logic                     init_q, init_d;
    logic                     init_error_q, init_error_d;

    logic                     sel_chg;
    logic                     running;
    logic signed [PW-1:0]     prod [NUM_CH];
    logic [NUM_CH*DATA_W-1:0] scaled;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c] = $signed({{(PW-DATA_W){proc_data[c*DATA_W+DATA_W-1]}},
                               proc_data[c*DATA_W +: DATA_W]})
                    * $signed({{(PW-GW){1'b0}}, gain_q});
            scaled[c*DATA_W +: DATA_W] = DATA_W'(prod[c] >>> RAMP_BITS);
        end
    end

    always_comb begin
        sync1_d      = fx_sel;
        sync2_d      = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        gain_d       = gain_q;
        fx_sel_out_d = fx_sel_out_q;
        init_error_d = init_error_q;
        sel_chg      = (sync2_q != fx_sel_out_q);

        unique case (state_q)
            S_HALT: begin
                state_d = S_INIT;
                cnt_d   = '0;
                gain_d  = '0;
            end
            S_INIT: begin
                if (init_finish) begin
                    state_d      = S_FADE_IN;
                    cnt_d        = '0;
                    gain_d       = '0;
                    fx_sel_out_d = sync2_q;
                end else if (cnt_q == TIMEOUT_V) begin
                    state_d      = S_ERROR;
                    cnt_d        = '0;
                    init_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ERROR: begin
                if (cnt_q == RETRY_V) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                gain_d = GMAX_V;
                if (sel_chg) state_d = S_FADE_OUT;
            end
            S_FADE_OUT: begin
                if (adc_valid && gain_q != '0) gain_d = gain_q - GW'(1);
                if (gain_q == '0) state_d = S_SWITCH;
            end
            S_SWITCH: begin
                fx_sel_out_d = sync2_q;
                state_d      = S_FADE_IN;
            end
            S_FADE_IN: begin
                if (adc_valid && gain_q != GMAX_V) gain_d = gain_q + GW'(1);
                // A new request reverses the ramp from wherever it is.
                if (sel_chg) state_d = S_FADE_OUT;
                else if (gain_q == GMAX_V) state_d = S_RUN;
            end
            default: state_d = S_HALT;
        endcase

        init_d  = !(state_d inside {S_HALT, S_ERROR});
        running = state_q inside {S_RUN, S_FADE_OUT, S_SWITCH, S_FADE_IN};

        dac_valid_d = 1'b0;
        dac_data_d  = dac_data_q;
        if (!running) begin
            dac_data_d = '0;
        end else if (adc_valid) begin
            dac_valid_d = 1'b1;
            dac_data_d  = scaled;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= S_HALT;
            cnt_q        <= '0;
            gain_q       <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            fx_sel_out_q <= '0;
            dac_data_q   <= '0;
            dac_valid_q  <= 1'b0;
            init_q       <= 1'b0;
            init_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gain_q       <= gain_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            fx_sel_out_q <= fx_sel_out_d;
            dac_data_q   <= dac_data_d;
            dac_valid_q  <= dac_valid_d;
            init_q       <= init_d;
            init_error_q <= init_error_d;
        end
    end

    assign init       = init_q;
    assign fx_sel_out = fx_sel_out_q;
    assign dac_data   = dac_data_q;
    assign dac_valid  = dac_valid_q;
    assign state_o    = state_q;
    assign init_error = init_error_q;

`ifdef CLIP_DETECT_EN
    localparam logic [DATA_W-1:0] MAX_P = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_N = {1'b1, {(DATA_W-1){1'b0}}};

    logic        clip_q, clip_d;
    logic [15:0] quiet_q, quiet_d;
    logic        hit;

    // Flag decays only after a full 2**16-frame run of clean frames.
    always_comb begin
        hit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (proc_data[c*DATA_W +: DATA_W] == MAX_P ||
                proc_data[c*DATA_W +: DATA_W] == MIN_N) hit = 1'b1;
        end
        clip_d  = clip_q;
        quiet_d = quiet_q;
        if (adc_valid && state_q inside {S_RUN, S_FADE_OUT, S_FADE_IN}) begin
            if (hit) begin
                clip_d  = 1'b1;
                quiet_d = '0;
            end else if (clip_q) begin
                if (quiet_q == 16'hFFFF) begin
                    clip_d  = 1'b0;
                    quiet_d = '0;
                end else begin
                    quiet_d = quiet_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            clip_q  <= 1'b0;
            quiet_q <= '0;
        end else begin
            clip_q  <= clip_d;
            quiet_q <= quiet_d;
        end
    end

    assign clip_flag = clip_q;
`endif

endmodule

// File: tb/tb_audio_path_ctrl.sv
// tb_audio_path_ctrl: directed sequence with random samples for
// audio_path_ctrl, checked against a frame-level gain/scale model.
`timescale 1ns/1ps
module tb_audio_path_ctrl;

    localparam int DW = 16;
    localparam int NC = 2;
    localparam int SW = 18;
    localparam int RB = 5;
    localparam int TO = 100;
    localparam int RT = 20;
    localparam int GM = 1 << RB;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             init;
    logic             init_finish = 1'b0;
    logic             adc_valid = 1'b0;
    logic [NC*DW-1:0] proc_data = '0;
    logic [SW-1:0]    fx_sel = '0;
    logic [SW-1:0]    fx_sel_out;
    logic [NC*DW-1:0] dac_data;
    logic             dac_valid;
    logic [2:0]       state_o;
    logic             init_error;
`ifdef CLIP_DETECT_EN
    logic             clip_flag;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mg;
    logic [DW-1:0] o0;

    always #5 Clk = ~Clk;

    audio_path_ctrl #(
        .DATA_W(DW), .NUM_CH(NC), .SEL_W(SW), .RAMP_BITS(RB),
        .INIT_TIMEOUT(TO), .RETRY_CYCLES(RT)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .init(init),
        .init_finish(init_finish),
        .adc_valid(adc_valid),
        .proc_data(proc_data),
        .fx_sel(fx_sel),
        .fx_sel_out(fx_sel_out),
        .dac_data(dac_data),
        .dac_valid(dac_valid),
        .state_o(state_o),
        .init_error(init_error)
`ifdef CLIP_DETECT_EN
        ,
        .clip_flag(clip_flag)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // floor(sample * gain / G_MAX)
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s,
                                            input int g);
        int sv, p, q;
        sv = int'($signed(s));
        p  = sv * g;
        q  = p / GM;
        if (p < 0 && (p % GM) != 0) q = q - 1;
        return q[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rnd();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r == 0) return 16'h7FFF;
        if (r == 1) return 16'h8000;
        return DW'($urandom);
    endfunction

    // One frame, 8 cycles long; mode 1 = last fade-out frame, 2 = last fade-in.
    task automatic frame(input logic [DW-1:0] s0, input int g, input int st,
                         input int mode, input logic [SW-1:0] nsel,
                         input string tag, output logic [DW-1:0] q0);
        logic [DW-1:0] s1;
        int idle;
        s1 = rnd();
        proc_data = {s1, s0};
        adc_valid = 1'b1;
        @(negedge Clk);
        adc_valid = 1'b0;
        q0 = dac_data[DW-1:0];
        chk({tag, "_vld"}, dac_valid, 1);
        chk({tag, "_ch0"}, dac_data[DW-1:0], scale(s0, g));
        chk({tag, "_ch1"}, dac_data[2*DW-1:DW], scale(s1, g));
        chk({tag, "_st"}, state_o, st);
        @(negedge Clk);
        chk({tag, "_pulse"}, dac_valid, 0);
        chk({tag, "_hold"}, dac_data, {scale(s1, g), scale(s0, g)});
        idle = 6;
        if (mode == 1) begin
            chk({tag, "_switch"}, state_o, 5);
            @(negedge Clk);
            chk({tag, "_fadein"}, state_o, 6);
            chk({tag, "_sel"}, fx_sel_out, nsel);
            idle = 5;
        end else if (mode == 2) begin
            chk({tag, "_run"}, state_o, 3);
        end
        repeat (idle) @(negedge Clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then init timeout and retry
        Reset  = 1'b0;
        fx_sel = 18'h00001;
        repeat (3) @(negedge Clk);
        chk("rst_state", state_o, 0);
        chk("rst_init", init, 0);
        chk("rst_dvld", dac_valid, 0);
        chk("rst_ddat", dac_data, 0);
        chk("rst_sel", fx_sel_out, 0);
        chk("rst_err", init_error, 0);
        Reset = 1'b1;
        for (int i = 1; i <= TO; i++) begin
            @(negedge Clk);
            chk("to_init_st", state_o, 1);
            chk("to_init_o", init, 1);
        end
        chk("to_err_pre", init_error, 0);
        @(negedge Clk);
        chk("to_err_st", state_o, 2);
        chk("to_err_init", init, 0);
        chk("to_err_flag", init_error, 1);
        for (int i = 2; i <= RT; i++) begin
            @(negedge Clk);
            chk("retry_st", state_o, 2);
            chk("retry_init", init, 0);
            chk("retry_ddat", dac_data, 0);
        end
        @(negedge Clk);
        chk("retry_back", state_o, 1);
        chk("retry_init1", init, 1);
        chk("err_sticky", init_error, 1);

        // Clean init with init_finish at cycle 10
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("rst2_err", init_error, 0);
        chk("rst2_state", state_o, 0);
        Reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge Clk);
            chk("boot_st", state_o, 1);
        end
        init_finish = 1'b1;
        @(negedge Clk);
        chk("boot_fadein", state_o, 6);
        chk("boot_sel", fx_sel_out, 18'h00001);
        chk("boot_err", init_error, 0);
        chk("boot_init", init, 1);
        repeat (3) @(negedge Clk);
        chk("boot_dvld", dac_valid, 0);

        // Fade-in 0..G_MAX, with a -1.0 sample at half gain
        mg = 0;
        for (int k = 0; k < GM; k++) begin
            frame((k == 16) ? 16'h8000 : 16'h4000, mg, 6,
                  (k == GM - 1) ? 2 : 0, '0, "fadein", o0);
            if (k == 16) chk("half_neg", o0, 16'hC000);
            if (k == 1) chk("first_step", o0, 16'h0200);
            mg++;
        end
        frame(16'h4000, mg, 3, 0, '0, "run_full", o0);
        chk("run_unity", o0, 16'h4000);
        frame(16'h7FFF, mg, 3, 0, '0, "run_max", o0);
        frame(rnd(), mg, 3, 0, '0, "run_rnd", o0);

        // Effect change in RUN: full fade-out, switch, partial fade-in
        fx_sel = 18'h00002;
        repeat (4) @(negedge Clk);
        chk("chg1_st", state_o, 4);
        chk("chg1_sel_old", fx_sel_out, 18'h00001);
        while (mg > 0) begin
            frame(rnd(), mg, 4, (mg == 1) ? 1 : 0, 18'h00002, "fadeout1", o0);
            mg--;
        end
        for (int k = 0; k < 10; k++) begin
            frame(rnd(), mg, 6, 0, '0, "fadein2", o0);
            mg++;
        end

        // Change during fade-in at gain 10: ramp reverses from 10
        fx_sel = 18'h00003;
        repeat (4) @(negedge Clk);
        chk("chg2_st", state_o, 4);
        while (mg > 0) begin
            frame(rnd(), mg, 4, (mg == 1) ? 1 : 0, 18'h00003, "fadeout2", o0);
            mg--;
        end
        for (int k = 0; k < 5; k++) begin
            frame(rnd(), mg, 6, 0, '0, "fadein3", o0);
            mg++;
        end

        // Reset in the middle of a fade-out
        fx_sel = 18'h00004;
        repeat (4) @(negedge Clk);
        chk("chg3_st", state_o, 4);
        for (int k = 0; k < 2; k++) begin
            frame(rnd(), mg, 4, 0, '0, "fadeout3", o0);
            mg--;
        end
        Reset     = 1'b0;
        adc_valid = 1'b1;
        proc_data = {rnd(), 16'h4000};
        @(negedge Clk);
        adc_valid = 1'b0;
        chk("abort_dvld", dac_valid, 0);
        chk("abort_ddat", dac_data, 0);
        chk("abort_sel", fx_sel_out, 0);
        chk("abort_st", state_o, 0);
        chk("abort_init", init, 0);
        Reset = 1'b1;
        @(negedge Clk);
        chk("restart_st", state_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
